// File: rtl/usb_bitstream_encoder_if.sv
// Handshake and bus bundle between the packet builder, the serialiser and the
// downstream bit-stuffing stage.
//   pktready : packet presented on pid/addr/data/endp
//   pause    : downstream stall, holds the current bit
//   pid      : 4-bit packet ID
//   addr     : 7-bit device address (token packets)
//   data     : 64-bit payload (data packets)
//   endp     : 4-bit endpoint (token packets)
//   outb     : serial bit out, 0 when idle
//   sending  : outb carries a valid packet bit
//   gotpkt   : one-cycle pulse, inputs captured at the end of this cycle
interface usb_bitstream_encoder_if;
   logic        pktready;
   logic        pause;
   logic [3:0]  pid;
   logic [6:0]  addr;
   logic [63:0] data;
   logic [3:0]  endp;
   logic        outb;
   logic        sending;
   logic        gotpkt;

   // Packet source / stall side
   modport master (
      output pktready, pause, pid, addr, data, endp,
      input  outb, sending, gotpkt
   );

   // Serialiser side
   modport slave (
      input  pktready, pause, pid, addr, data, endp,
      output outb, sending, gotpkt
   );
endinterface

// File: rtl/usb_bitstream_encoder.sv
// Serialises one USB-style packet (PID, then addr+endp or a 64-bit payload)
// LSB first onto a single bit, one bit per un-paused clock.
//   clk   : system clock, rising edge
//   rst_L : asynchronous active-low reset
//   bus   : slave side of usb_bitstream_encoder_if (handshake, fields, serial out)
module usb_bitstream_encoder (
   input logic                    clk,
   input logic                    rst_L,
   usb_bitstream_encoder_if.slave bus
);

   localparam int unsigned PID_BITS  = 8;
   localparam int unsigned ADDR_BITS = 7;
   localparam int unsigned ENDP_BITS = 4;
   localparam int unsigned DATA_BITS = 64;
   localparam int unsigned CNT_W     = 8;

   localparam logic [3:0] PID_OUT = 4'b0001;
   localparam logic [3:0] PID_IN  = 4'b1001;
   localparam logic [3:0] PID_ACK = 4'b0010;
   localparam logic [3:0] PID_NAK = 4'b1010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND_PID,
      S_SEND_ADDR,
      S_SEND_ENDP,
      S_SEND_DATA
   } state_t;

   state_t                 r_state;
   logic [3:0]             r_pid_save;
   logic [PID_BITS-1:0]    r_pid_sr;
   logic [ADDR_BITS-1:0]   r_addr_sr;
   logic [ENDP_BITS-1:0]   r_endp_sr;
   logic [DATA_BITS-1:0]   r_data_sr;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_outb;
   logic                   r_sending;
   logic                   r_gotpkt;

   state_t                 w_after_pid;
   logic                   w_after_pid_bit;

   // Packet type decode from the PID captured at LOAD (live pid may have moved on)
   always_comb begin
      w_after_pid     = S_SEND_DATA;
      w_after_pid_bit = r_data_sr[0];
      case (r_pid_save)
         PID_ACK, PID_NAK: begin
            w_after_pid     = S_IDLE;
            w_after_pid_bit = 1'b0;
         end
         PID_OUT, PID_IN: begin
            w_after_pid     = S_SEND_ADDR;
            w_after_pid_bit = r_addr_sr[0];
         end
         default: begin
            w_after_pid     = S_SEND_DATA;
            w_after_pid_bit = r_data_sr[0];
         end
      endcase
   end

   // FSM, shift registers and counter; outb/sending are precomputed one edge
   // ahead so they line up with the state that shows the bit.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_state    <= S_IDLE;
         r_pid_save <= '0;
         r_pid_sr   <= '0;
         r_addr_sr  <= '0;
         r_endp_sr  <= '0;
         r_data_sr  <= '0;
         r_cnt      <= '0;
         r_outb     <= 1'b0;
         r_sending  <= 1'b0;
         r_gotpkt   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_outb    <= 1'b0;
               r_sending <= 1'b0;
               r_gotpkt  <= bus.pktready;
               if (bus.pktready) r_state <= S_LOAD;
            end

            S_LOAD: begin
               r_pid_save <= bus.pid;
               r_pid_sr   <= {~bus.pid, bus.pid};
               r_addr_sr  <= bus.addr;
               r_endp_sr  <= bus.endp;
               r_data_sr  <= bus.data;
               r_cnt      <= '0;
               r_gotpkt   <= 1'b0;
               r_outb     <= bus.pid[0];
               r_sending  <= 1'b1;
               r_state    <= S_SEND_PID;
            end

            S_SEND_PID: begin
               if (!bus.pause) begin
                  r_pid_sr <= r_pid_sr >> 1;
                  if (r_cnt == CNT_W'(PID_BITS - 1)) begin
                     r_cnt     <= '0;
                     r_state   <= w_after_pid;
                     r_outb    <= w_after_pid_bit;
                     r_sending <= (w_after_pid != S_IDLE);
                  end else begin
                     r_cnt  <= r_cnt + CNT_W'(1);
                     r_outb <= r_pid_sr[1];
                  end
               end
            end

            S_SEND_ADDR: begin
               if (!bus.pause) begin
                  r_addr_sr <= r_addr_sr >> 1;
                  if (r_cnt == CNT_W'(ADDR_BITS - 1)) begin
                     r_cnt   <= '0;
                     r_state <= S_SEND_ENDP;
                     r_outb  <= r_endp_sr[0];
                  end else begin
                     r_cnt  <= r_cnt + CNT_W'(1);
                     r_outb <= r_addr_sr[1];
                  end
               end
            end

            S_SEND_ENDP: begin
               if (!bus.pause) begin
                  r_endp_sr <= r_endp_sr >> 1;
                  if (r_cnt == CNT_W'(ENDP_BITS - 1)) begin
                     r_cnt     <= '0;
                     r_state   <= S_IDLE;
                     r_outb    <= 1'b0;
                     r_sending <= 1'b0;
                  end else begin
                     r_cnt  <= r_cnt + CNT_W'(1);
                     r_outb <= r_endp_sr[1];
                  end
               end
            end

            S_SEND_DATA: begin
               if (!bus.pause) begin
                  r_data_sr <= r_data_sr >> 1;
                  if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
                     r_cnt     <= '0;
                     r_state   <= S_IDLE;
                     r_outb    <= 1'b0;
                     r_sending <= 1'b0;
                  end else begin
                     r_cnt  <= r_cnt + CNT_W'(1);
                     r_outb <= r_data_sr[1];
                  end
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_outb    <= 1'b0;
               r_sending <= 1'b0;
               r_gotpkt  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.outb    = r_outb;
   assign bus.sending = r_sending;
   assign bus.gotpkt  = r_gotpkt;

endmodule

// File: tb/tb_usb_bitstream_encoder.sv
// Self-checking bench for usb_bitstream_encoder: directed packets from the
// test plan plus randomized packets/pauses against a bit-list reference model.
module tb_usb_bitstream_encoder;

   logic clk;
   logic rst_L;
   int   errors;
   int   checks;
   logic exp_q[$];

   usb_bitstream_encoder_if u_if ();

   usb_bitstream_encoder u_dut (
      .clk   (clk),
      .rst_L (rst_L),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the wire sequence of a packet is just the field bits, LSB first
   function automatic void model(input logic [3:0] p, input logic [6:0] a,
                                 input logic [63:0] d, input logic [3:0] e);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(p[i]);
      for (int i = 0; i < 4; i++) exp_q.push_back(~p[i]);
      if (p == 4'b0010 || p == 4'b1010) begin
      end else if (p == 4'b0001 || p == 4'b1001) begin
         for (int i = 0; i < 7; i++) exp_q.push_back(a[i]);
         for (int i = 0; i < 4; i++) exp_q.push_back(e[i]);
      end else begin
         for (int i = 0; i < 64; i++) exp_q.push_back(d[i]);
      end
   endfunction

   task automatic scramble_inputs();
      u_if.pid  = 4'($urandom);
      u_if.addr = 7'($urandom);
      u_if.endp = 4'($urandom);
      u_if.data = {$urandom, $urandom};
   endtask

   // Waits (bounded) for the LOAD cycle; returns at its falling edge
   task automatic wait_gotpkt(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (u_if.gotpkt === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s gotpkt: never seen within 20 cycles", name);
      end else begin
         checks++;
         if (u_if.sending !== 1'b0) begin
            errors++;
            $display("FAIL %s load_sending: got %b want 0", name, u_if.sending);
         end
      end
   endtask

   // Collects one packet's serial bits starting the cycle after LOAD, inserting
   // plen pause cycles when bit index pstart is on the wire; returns at the
   // falling edge of the first non-sending cycle.
   task automatic collect(input string name, input int pstart, input int plen);
      logic got[$];
      int   cycles = 0, consumed = 0, pcnt = 0, bad_idx = -1;
      bit   gp_bad = 0, hold_bad = 0, first_bad = 0, timeout = 1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (u_if.sending !== 1'b1) begin
            if (c == 0) first_bad = 1;
            timeout = 0;
            break;
         end
         cycles++;
         if (u_if.gotpkt !== 1'b0) gp_bad = 1;
         if (u_if.pause) begin
            if (consumed >= exp_q.size() || u_if.outb !== exp_q[consumed]) hold_bad = 1;
         end else begin
            got.push_back(u_if.outb);
            consumed++;
         end
         @(posedge clk);
         #1;
         if (consumed == pstart && pcnt < plen) begin
            u_if.pause = 1'b1;
            pcnt++;
         end else begin
            u_if.pause = 1'b0;
         end
      end
      u_if.pause = 1'b0;

      checks++;
      if (timeout) begin
         errors++;
         $display("FAIL %s end: sending never dropped within 300 cycles", name);
      end
      checks++;
      if (first_bad) begin
         errors++;
         $display("FAIL %s latency: sending=0 in cycle after LOAD, want 1", name);
      end
      checks++;
      if (cycles != exp_q.size() + plen) begin
         errors++;
         $display("FAIL %s length: got %0d sending cycles want %0d", name, cycles, exp_q.size() + plen);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            bad_idx = i;
            break;
         end
      end
      checks++;
      if (bad_idx >= 0) begin
         errors++;
         $display("FAIL %s bits: first wrong bit index %0d got %b want %b", name, bad_idx,
                  (bad_idx < got.size()) ? got[bad_idx] : 1'bx, exp_q[bad_idx]);
      end
      if (plen > 0) begin
         checks++;
         if (hold_bad) begin
            errors++;
            $display("FAIL %s pause_hold: outb changed while paused, want %b held", name, exp_q[pstart]);
         end
      end
      checks++;
      if (gp_bad) begin
         errors++;
         $display("FAIL %s gotpkt_during_send: got 1 want 0", name);
      end
      checks++;
      if (!timeout && u_if.outb !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_outb: got %b want 0", name, u_if.outb);
      end
   endtask

   task automatic run_pkt(input string name, input logic [3:0] p, input logic [6:0] a,
                          input logic [63:0] d, input logic [3:0] e,
                          input int pstart, input int plen);
      bit ok;
      @(posedge clk);
      #1;
      u_if.pid = p; u_if.addr = a; u_if.data = d; u_if.endp = e;
      u_if.pktready = 1'b1;
      model(p, a, d, e);
      wait_gotpkt(name, ok);
      if (!ok) begin
         u_if.pktready = 1'b0;
         return;
      end
      // Source moves on after gotpkt; the packet must come from captured values
      @(posedge clk);
      #1;
      u_if.pktready = 1'b0;
      scramble_inputs();
      collect(name, pstart, plen);
      @(negedge clk);
      checks++;
      if (u_if.sending !== 1'b0 || u_if.gotpkt !== 1'b0) begin
         errors++;
         $display("FAIL %s stays_idle: sending=%b gotpkt=%b want 0 0", name, u_if.sending, u_if.gotpkt);
      end
   endtask

   task automatic test_reset();
      rst_L = 1'b0;
      u_if.pktready = 1'b0; u_if.pause = 1'b0;
      u_if.pid = '0; u_if.addr = '0; u_if.data = '0; u_if.endp = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (u_if.outb !== 1'b0 || u_if.sending !== 1'b0 || u_if.gotpkt !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: outb=%b sending=%b gotpkt=%b want 0 0 0",
                  u_if.outb, u_if.sending, u_if.gotpkt);
      end
      rst_L = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (u_if.outb !== 1'b0 || u_if.sending !== 1'b0 || u_if.gotpkt !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: outb=%b sending=%b gotpkt=%b want 0 0 0",
                  u_if.outb, u_if.sending, u_if.gotpkt);
      end
   endtask

   task automatic test_ack();
      run_pkt("ack", 4'b0010, 7'h55, 64'hdead_beef_0123_4567, 4'h9, 0, 0);
      run_pkt("nak", 4'b1010, 7'h2a, 64'h0, 4'h3, 0, 0);
   endtask

   task automatic test_out();
      run_pkt("out", 4'b0001, 7'b1101101, 64'h0, 4'b1101, 0, 0);
   endtask

   task automatic test_data0();
      run_pkt("data0", 4'b0011, 7'h00, 64'h8000_0000_0000_0001, 4'h0, 0, 0);
   endtask

   task automatic test_pause();
      // Third address bit is wire index 10
      run_pkt("pause_out", 4'b0001, 7'b1101101, 64'h0, 4'b1101, 10, 3);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen = 0;
      @(posedge clk);
      #1;
      u_if.pid = 4'b0011; u_if.data = '1; u_if.pktready = 1'b1;
      wait_gotpkt("rst_mid", ok);
      @(posedge clk);
      #1;
      u_if.pktready = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (u_if.sending !== 1'b1 || u_if.outb !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: sending=%b outb=%b want 1 1", u_if.sending, u_if.outb);
      end
      #1;
      rst_L = 1'b0;
      #1;
      checks++;
      if (u_if.outb !== 1'b0 || u_if.sending !== 1'b0 || u_if.gotpkt !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_abort: outb=%b sending=%b gotpkt=%b want 0 0 0",
                  u_if.outb, u_if.sending, u_if.gotpkt);
      end
      @(negedge clk);
      rst_L = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (u_if.sending !== 1'b0 || u_if.gotpkt !== 1'b0 || u_if.outb !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rst_mid_no_resume: activity after reset without pktready, want none");
      end
      run_pkt("after_rst", 4'b1001, 7'h11, 64'h0, 4'h6, 0, 0);
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [6:0] a2 = 7'($urandom);
      logic [3:0] e2 = 4'($urandom);
      @(posedge clk);
      #1;
      u_if.pid = 4'b1001; u_if.addr = 7'b0110011; u_if.endp = 4'b1010;
      u_if.pktready = 1'b1;
      model(4'b1001, 7'b0110011, 64'h0, 4'b1010);
      wait_gotpkt("b2b_in", ok);
      if (!ok) begin
         u_if.pktready = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      u_if.pid = 4'b0010; u_if.addr = a2; u_if.endp = e2; u_if.data = {$urandom, $urandom};
      collect("b2b_in", 0, 0);
      checks++;
      if (u_if.gotpkt !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_gap: gotpkt=%b in idle cycle want 0", u_if.gotpkt);
      end
      @(negedge clk);
      checks++;
      if (u_if.gotpkt !== 1'b1 || u_if.sending !== 1'b0) begin
         errors++;
         $display("FAIL b2b_load: gotpkt=%b sending=%b want 1 0", u_if.gotpkt, u_if.sending);
      end
      model(4'b0010, a2, 64'h0, e2);
      @(posedge clk);
      #1;
      u_if.pktready = 1'b0;
      scramble_inputs();
      collect("b2b_ack", 0, 0);
   endtask

   task automatic test_random();
      logic [3:0] p;
      int len, ps, pl;
      for (int n = 0; n < 12; n++) begin
         case ($urandom_range(0, 5))
            0: p = 4'b0010;
            1: p = 4'b1010;
            2: p = 4'b0001;
            3: p = 4'b1001;
            4: p = 4'b0011;
            default: p = 4'($urandom);
         endcase
         len = (p == 4'b0010 || p == 4'b1010) ? 8 : (p == 4'b0001 || p == 4'b1001) ? 19 : 72;
         pl  = $urandom_range(0, 3);
         ps  = $urandom_range(1, len - 1);
         run_pkt($sformatf("rand%0d", n), p, 7'($urandom), {$urandom, $urandom},
                 4'($urandom), ps, pl);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_ack();
      test_out();
      test_data0();
      test_pause();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
